csa_frame_accum: RTL and testbench
==================================

# csa_frame_accum

Parametrised, pipelined successor to the single-bit INV/NOR2/XOR2/FA slice. Each accepted beat forms a WIDTH-bit three-term sum (a XOR b) + NOR(c,d) + NOT e through a row of full adders. The sum is folded into a carry-save accumulator, and the result is resolved once per frame of up to COUNT beats. The block sits between operand producers and any downstream consumer of frame totals, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, bit width of each input operand
- ACC_WIDTH, 16, accumulator and result width; must be ≥ WIDTH+2
- COUNT, 4, maximum beats per frame; must be ≥ 1
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  beat offered
- in_ready  output  1  block accepts a beat this cycle
- in_a, in_b, in_c, in_d, in_e  input  WIDTH each  beat operands
- in_last  input  1  beat closes the frame early
- out_valid  output  1  frame result held
- out_ready  input  1  consumer takes result
- out_sum  output  ACC_WIDTH  frame total, modulo 2^ACC_WIDTH
- out_beats  output  $clog2(COUNT+1)  beats in the frame

## Operation
- Beat term, zero-extended to ACC_WIDTH: t = (a^b) + ~(c|d) + ~e. It is formed by a 3:2 compressor row whose outputs are sum vector s and carry vector cy<<1.
- The accumulator holds a carry-save pair (acc_s, acc_c). Each accepted beat compresses {acc_s, acc_c, t_s, t_c} 4:2 into a new pair. All arithmetic wraps modulo 2^ACC_WIDTH, and no overflow flag is produced.
- FSM states:
  - IDLE: in_ready=1. The pair is zero. An accepted beat moves to ACCUM with beat_cnt=1. If that beat has in_last=1, or COUNT=1, the next state is RESOLVE instead.
  - ACCUM: in_ready=1. An accepted beat increments beat_cnt. If in_last=1 or beat_cnt reaches COUNT, the next state is RESOLVE.
  - RESOLVE: in_ready=0. out_sum is set to acc_s + acc_c with a carry-propagate add, and out_beats to beat_cnt. The pair clears and the FSM moves to HOLD. This state lasts exactly one cycle.
  - HOLD: in_ready=0 and out_valid=1. On out_ready=1 the FSM returns to IDLE.
- Without a handshake, all outputs are stable throughout HOLD.
- in_last is ignored unless it arrives with an accepted beat.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_beats=0, FSM in IDLE, pair zero, beat_cnt=0.
- Latency: if the closing beat is accepted at cycle k, out_valid rises at k+2.
- Throughput: one beat per cycle inside a frame. There are at least two bubble cycles between frames: RESOLVE, then HOLD for one or more cycles.
- out_ready=1 in HOLD: out_valid falls next cycle and in_ready rises next cycle. There is no same-cycle bypass.
- in_valid while in_ready=0: the beat is not consumed. The producer must hold it.
- Reset asserted mid-frame or in HOLD: the partial frame is discarded immediately, and outputs return to their reset values asynchronously.
- out_sum and out_beats are registered. No combinational path from any input to any output except through the FSM state.

## Structure
- Package csa_frame_accum_pkg holds:
  - the state enum {IDLE, ACCUM, RESOLVE, HOLD};
  - a function computing beat-counter width from COUNT;
  - elaboration checks on ACC_WIDTH ≥ WIDTH+2 and COUNT ≥ 1.
- Sub-module csa_3to2: a parametrised full-adder row (width param). It is instantiated once for the beat term and twice for the 4:2 accumulator compression.

## Test plan
- WIDTH=8, ACC_WIDTH=16, COUNT=4. Four beats of a=0xFF, b=0x0F, c=0, d=0, e=0 (t=0x2EE each), no in_last -> out_sum=0xBB8, out_beats=4, out_valid exactly 2 cycles after the 4th accept.
- Same stimulus with ACC_WIDTH=10 -> out_sum=0x3B8 (wrap), out_beats=4.
- Beat t=0x2EE, then a=b=0, c=d=e=0xFF (t=0) with in_last=1 -> out_sum=0x2EE, out_beats=2.
- Hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready stays 0, out_sum is stable, and no beat is consumed. Raising out_ready -> IDLE next cycle and accumulation restarts from zero.
- Assert rst_n=0 after 2 beats, release, then send one beat t=0x2EE with in_last=1 -> out_sum=0x2EE, out_beats=1.
- Randomised a–e across 1000 frames with random in_last and out_ready backpressure -> out_sum matches the reference model's modular sum, and out_beats matches the number of accepted beats in each frame.

Source files
------------

// File: rtl/csa_frame_accum_pkg.sv
// Shared types and helpers for the carry-save frame accumulator.
// Holds the FSM encoding, counter sizing and parameter sanity checks.
package csa_frame_accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        HOLD
    } state_t;

    function automatic int cnt_width(input int count);
        return $clog2(count + 1);
    endfunction

    function automatic bit params_ok(
        input int width,
        input int acc_width,
        input int count
    );
        return (acc_width >= width + 2) && (count >= 1);
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Row of full adders: three vectors in, sum and unshifted carry out.
// Callers apply the carry weight shift themselves.
module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] cy
);

    assign s  = x ^ y ^ z;
    assign cy = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_frame_accum.sv
// Per-frame accumulator of (a^b) + ~(c|d) + ~e kept in carry-save form.
// A single carry-propagate add resolves the pair once per frame.
module csa_frame_accum
    import csa_frame_accum_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [WIDTH-1:0]           in_c,
    input  logic [WIDTH-1:0]           in_d,
    input  logic [WIDTH-1:0]           in_e,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       out_sum,
    output logic [$clog2(COUNT+1)-1:0] out_beats
);

    localparam int BW  = cnt_width(COUNT);
    localparam int PAD = ACC_WIDTH - WIDTH;
    localparam logic [BW-1:0] CNT_MAX = BW'(COUNT);

    if (!params_ok(WIDTH, ACC_WIDTH, COUNT)) begin : g_bad_params
        $error("csa_frame_accum: need ACC_WIDTH >= WIDTH+2 and COUNT >= 1");
    end

    state_t state;
    logic [ACC_WIDTH-1:0] acc_s, acc_c;
    logic [BW-1:0] beat_cnt, cnt_next;

    logic [ACC_WIDTH-1:0] op_x, op_y, op_z;
    logic [ACC_WIDTH-1:0] t_s, t_cy, t_c;
    logic [ACC_WIDTH-1:0] m_s, m_cy, m_c;
    logic [ACC_WIDTH-1:0] n_s, n_cy, n_c;

    assign op_x = {{PAD{1'b0}}, in_a ^ in_b};
    assign op_y = {{PAD{1'b0}}, ~(in_c | in_d)};
    assign op_z = {{PAD{1'b0}}, ~in_e};

    csa_3to2 #(.W(ACC_WIDTH)) u_term (
        .x(op_x), .y(op_y), .z(op_z), .s(t_s), .cy(t_cy)
    );
    assign t_c = {t_cy[ACC_WIDTH-2:0], 1'b0};

    // 4:2 compression of {acc_s, acc_c, t_s, t_c} as two 3:2 rows
    csa_3to2 #(.W(ACC_WIDTH)) u_c42_a (
        .x(acc_s), .y(acc_c), .z(t_s), .s(m_s), .cy(m_cy)
    );
    assign m_c = {m_cy[ACC_WIDTH-2:0], 1'b0};

    csa_3to2 #(.W(ACC_WIDTH)) u_c42_b (
        .x(m_s), .y(m_c), .z(t_c), .s(n_s), .cy(n_cy)
    );
    assign n_c = {n_cy[ACC_WIDTH-2:0], 1'b0};

    assign cnt_next = beat_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            acc_s     <= '0;
            acc_c     <= '0;
            beat_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc_s    <= n_s;
                        acc_c    <= n_c;
                        beat_cnt <= cnt_next;
                        if (in_last || cnt_next == CNT_MAX) begin
                            state    <= RESOLVE;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum   <= acc_s + acc_c;
                    out_beats <= beat_cnt;
                    acc_s     <= '0;
                    acc_c     <= '0;
                    beat_cnt  <= '0;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_frame_accum.sv
// Bench for csa_frame_accum: directed vectors, corner sequences and a
// randomised scoreboard run against 16-bit and 10-bit accumulators.
module tb_csa_frame_accum;

    localparam int W   = 8;
    localparam int CNT = 4;
    localparam int BW  = $clog2(CNT + 1);

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_last, out_ready;
    logic [W-1:0] in_a, in_b, in_c, in_d, in_e;

    logic in_ready, out_valid;
    logic [15:0] out_sum;
    logic [BW-1:0] out_beats;
    logic in_ready10, out_valid10;
    logic [9:0] out_sum10;
    logic [BW-1:0] out_beats10;

    always #5 clk = ~clk;

    csa_frame_accum #(.WIDTH(W), .ACC_WIDTH(16), .COUNT(CNT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
        .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_beats(out_beats)
    );

    csa_frame_accum #(.WIDTH(W), .ACC_WIDTH(10), .COUNT(CNT)) u_dut10 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready10),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
        .in_last(in_last),
        .out_valid(out_valid10), .out_ready(out_ready),
        .out_sum(out_sum10), .out_beats(out_beats10)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int beat_t(input logic [7:0] a, b, c, d, e);
        logic [7:0] x, y, z;
        x = a ^ b;
        y = ~(c | d);
        z = ~e;
        return int'(x) + int'(y) + int'(z);
    endfunction

    typedef struct {
        int sum;
        int sum10;
        int beats;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;
    int m_acc = 0;
    int m_beats = 0;
    int frames_done = 0;

    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            sb.delete();
            m_acc = 0;
            m_beats = 0;
        end else begin
            if (in_valid && in_ready) begin
                m_acc += beat_t(in_a, in_b, in_c, in_d, in_e);
                m_beats++;
                if (in_last || m_beats == CNT) begin
                    sb.push_back('{m_acc & 'hFFFF, m_acc & 'h3FF, m_beats});
                    m_acc = 0;
                    m_beats = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", 1, 0);
                end else begin
                    sb_e = sb.pop_front();
                    check("sb_sum", 32'(out_sum), sb_e.sum);
                    check("sb_sum10", 32'(out_sum10), sb_e.sum10);
                    check("sb_beats", 32'(out_beats), sb_e.beats);
                    check("sb_valid10", 32'(out_valid10), 1);
                    frames_done++;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] a, b, c, d, e,
                             input logic last);
        bit took;
        took = 1'b0;
        in_a = a; in_b = b; in_c = c; in_d = d; in_e = e;
        in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            sync();
        end
        if (!took) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        int i;
        n = 0;
        i = 0;
        while (n == 0 && i < 50) begin
            i++;
            @(negedge clk);
            if (out_valid) n = i;
        end
        if (n == 0) check("valid_timeout", 0, 1);
    endtask

    typedef struct {
        logic [7:0] a, b, c, d, e;
        int sum;
    } vec_t;

    vec_t tbl[6];
    int lat;
    int f0;
    bit rand_on;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 'h2EE};
        tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 'h1FE};
        tbl[2] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 'h0FF};
        tbl[3] = '{8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h80, 'h17E};
        tbl[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 'h000};
        tbl[5] = '{8'h12, 8'h34, 8'h01, 8'h02, 8'hFE, 'h123};

        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_e = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_beats", 32'(out_beats), 0);
        sync();
        rst_n = 1'b1;

        // full frame of four beats, no in_last
        repeat (4) send_beat(8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_valid(lat);
        check("full_latency", lat, 2);
        check("full_sum", 32'(out_sum), 'hBB8);
        check("full_sum10", 32'(out_sum10), 'h3B8);
        check("full_beats", 32'(out_beats), 4);
        check("full_beats10", 32'(out_beats10), 4);

        foreach (tbl[i]) begin
            sync();
            send_beat(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].e, 1'b1);
            wait_valid(lat);
            check($sformatf("tbl%0d_sum", i), 32'(out_sum), tbl[i].sum);
            check($sformatf("tbl%0d_sum10", i), 32'(out_sum10),
                  tbl[i].sum & 'h3FF);
            check($sformatf("tbl%0d_beats", i), 32'(out_beats), 1);
        end

        // early close on in_last
        sync();
        send_beat(8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 1'b0);
        send_beat(8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        wait_valid(lat);
        check("early_sum", 32'(out_sum), 'h2EE);
        check("early_beats", 32'(out_beats), 2);

        // backpressure in HOLD with a beat waiting
        sync();
        out_ready = 1'b0;
        send_beat(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        wait_valid(lat);
        sync();
        in_a = 8'h00; in_b = 8'h00; in_c = 8'h00; in_d = 8'h00; in_e = 8'h00;
        in_last = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_out_sum", 32'(out_sum), 'h0FF);
        end
        sync();
        out_ready = 1'b1;
        sync();
        @(negedge clk);
        check("release_out_valid", 32'(out_valid), 0);
        check("release_in_ready", 32'(in_ready), 1);
        sync();
        in_valid = 1'b0;
        in_last = 1'b0;
        wait_valid(lat);
        check("restart_latency", lat, 2);
        check("restart_sum", 32'(out_sum), 'h1FE);
        check("restart_beats", 32'(out_beats), 1);

        // reset mid-frame
        sync();
        send_beat(8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 1'b0);
        send_beat(8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_sum", 32'(out_sum), 0);
        check("midrst_out_beats", 32'(out_beats), 0);
        sync();
        rst_n = 1'b1;
        send_beat(8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 1'b1);
        wait_valid(lat);
        check("postrst_sum", 32'(out_sum), 'h2EE);
        check("postrst_beats", 32'(out_beats), 1);

        // reset while holding a result
        sync();
        out_ready = 1'b0;
        send_beat(8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h80, 1'b1);
        wait_valid(lat);
        #2 rst_n = 1'b0;
        #1;
        check("holdrst_out_valid", 32'(out_valid), 0);
        check("holdrst_out_sum", 32'(out_sum), 0);
        check("holdrst_in_ready", 32'(in_ready), 1);
        sync();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // randomised frames with backpressure
        f0 = frames_done;
        rand_on = 1'b1;
        fork
            begin
                while (frames_done < f0 + 1000) begin
                    if ($urandom_range(3) == 0) begin
                        in_last = 1'($urandom_range(1));
                        sync();
                        in_last = 1'b0;
                    end else begin
                        send_beat(8'($urandom), 8'($urandom), 8'($urandom),
                                  8'($urandom), 8'($urandom),
                                  $urandom_range(2) == 0);
                    end
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    sync();
                    out_ready = $urandom_range(2) != 0;
                end
            end
        join
        out_ready = 1'b1;
        send_beat(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1'b1);
        repeat (6) sync();
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
